// File: rtl/trap_peak_detector_pkg.sv
// Shared settings for the trapezoidal peak detector slice: default geometry,
// detector state encoding and the event record carried through the FIFO.
package package_settings_V1;

   localparam int SIZE_OUT_DATA  = 16;
   localparam int PD_TS_W        = 32;
   localparam int PD_PEAK_DELAY  = 8;
   localparam int PD_MAX_WIDTH   = 64;
   localparam int PD_FIFO_DEPTH  = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RISE = 2'd1,
      FALL = 2'd2
   } pd_state_t;

   typedef struct packed {
      logic [SIZE_OUT_DATA-1:0] amp;
      logic [PD_TS_W-1:0]       tstamp;
      logic                     pileup;
   } pd_event_t;

endpackage

// File: rtl/trap_peak_detector_fifo.sv
// peak_event_fifo: synchronous show-ahead FIFO of pd_event_t.
// The head entry and valid flag are registers computed from next-state, so
// readout sees stable, glitch-free outputs. A pop and a push in the same cycle
// both take effect, even when full (the pop frees the slot first).
module peak_event_fifo
   import package_settings_V1::*;
#(
   parameter int DEPTH = PD_FIFO_DEPTH
)(
   input  logic      clk,
   input  logic      reset,
   input  logic      push,
   input  pd_event_t push_data,
   output logic      full,
   input  logic      ready,
   output logic      valid,
   output pd_event_t head
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);

   pd_event_t        mem_r [DEPTH];
   logic [PTR_W-1:0] wr_ptr_r;
   logic [PTR_W-1:0] rd_ptr_r;
   logic [PTR_W-1:0] rd_ptr_next_s;
   logic [CNT_W-1:0] count_r;
   logic [CNT_W-1:0] count_next_s;
   pd_event_t        head_r;
   pd_event_t        head_next_s;
   logic             valid_r;
   logic             full_s;
   logic             do_pop_s;
   logic             do_push_s;

   // Next-state of pointers, occupancy and the entry that will sit at the head
   always_comb begin
      full_s       = (count_r == CNT_W'(DEPTH));
      do_pop_s     = valid_r && ready;
      do_push_s    = push && (!full_s || do_pop_s);
      if (do_pop_s) begin
         rd_ptr_next_s = rd_ptr_r + PTR_W'(1);
      end else begin
         rd_ptr_next_s = rd_ptr_r;
      end
      count_next_s = count_r + CNT_W'(do_push_s) - CNT_W'(do_pop_s);
      // When the queue is (or becomes) empty apart from the incoming entry,
      // the new head is the data being written this cycle.
      if (do_push_s && (wr_ptr_r == rd_ptr_next_s)) begin
         head_next_s = push_data;
      end else begin
         head_next_s = mem_r[rd_ptr_next_s];
      end
   end

   // Storage, pointers and registered head/valid
   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_ptr_r <= {PTR_W{1'b0}};
         rd_ptr_r <= {PTR_W{1'b0}};
         count_r  <= {CNT_W{1'b0}};
         valid_r  <= 1'b0;
         head_r   <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= '0;
         end
      end else begin
         if (do_push_s) begin
            mem_r[wr_ptr_r] <= push_data;
            wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
         end
         rd_ptr_r <= rd_ptr_next_s;
         count_r  <= count_next_s;
         valid_r  <= (count_next_s != {CNT_W{1'b0}});
         head_r   <= head_next_s;
      end
   end

   assign full  = full_s;
   assign valid = valid_r;
   assign head  = head_r;

endmodule

// File: rtl/trap_peak_detector.sv
// trap_peak_detector: threshold trigger and flat-top amplitude sampler that
// sits behind the trapezoidal shaping filter. Each accepted pulse becomes an
// {amplitude, crossing timestamp, pile-up} event queued for readout.
// Build option: define PILEUP_REJECT_EN to discard pile-up pulses (each one
// counted in drop_cnt) instead of queueing them with ev_pileup set.
module trap_peak_detector
   import package_settings_V1::*;
#(
   parameter int DATA_W     = SIZE_OUT_DATA,
   parameter int TS_W       = PD_TS_W,
   parameter int PEAK_DELAY = PD_PEAK_DELAY,
   parameter int MAX_WIDTH  = PD_MAX_WIDTH,
   parameter int FIFO_DEPTH = PD_FIFO_DEPTH,
   parameter int DROP_W     = 16
)(
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] filt_data,
   input  logic [DATA_W-1:0] thresh,
   output logic              ev_valid,
   input  logic              ev_ready,
   output logic [DATA_W-1:0] ev_amp,
   output logic [TS_W-1:0]   ev_time,
   output logic              ev_pileup,
   output logic [DROP_W-1:0] drop_cnt
);

   localparam int WCNT_W = $clog2(MAX_WIDTH + 2);

   pd_state_t         state_r;
   logic [TS_W-1:0]   ts_r;
   logic [TS_W-1:0]   t0_r;
   logic [DATA_W-1:0] amp_r;
   logic [WCNT_W-1:0] wcnt_r;
   logic [WCNT_W-1:0] wcnt_inc_s;
   logic              pile_r;
   logic              pile_s;
   logic [DROP_W-1:0] drop_cnt_r;

   logic              above_s;
   logic              end_of_pulse_s;
   logic              push_s;
   logic              drop_s;
   logic              pop_s;
   logic              fifo_full_s;
   logic              fifo_valid_s;
   pd_event_t         event_s;
   pd_event_t         head_s;

   // Trigger compare, pulse-end decision and FIFO push/drop steering
   always_comb begin
      above_s = (filt_data > thresh);
      // Width counter stops one past MAX_WIDTH: enough to flag pile-up forever.
      if (wcnt_r >= WCNT_W'(MAX_WIDTH + 1)) begin
         wcnt_inc_s = wcnt_r;
      end else begin
         wcnt_inc_s = wcnt_r + WCNT_W'(1);
      end
      // wcnt equals the number of above samples seen so far, so the pulse is
      // pile-up once that count exceeds MAX_WIDTH, including the final sample.
      pile_s         = pile_r || (wcnt_r > WCNT_W'(MAX_WIDTH));
      end_of_pulse_s = (state_r == FALL) && !above_s;
      pop_s          = fifo_valid_s && ev_ready;
      event_s        = '0;
      event_s.amp    = amp_r;
      event_s.tstamp = t0_r;
`ifdef PILEUP_REJECT_EN
      event_s.pileup = 1'b0;
      push_s         = end_of_pulse_s && !pile_s;
      drop_s         = end_of_pulse_s && (pile_s || (fifo_full_s && !pop_s));
`else
      event_s.pileup = pile_s;
      push_s         = end_of_pulse_s;
      drop_s         = end_of_pulse_s && fifo_full_s && !pop_s;
`endif
   end

   // Timestamp, drop counter and IDLE -> RISE -> FALL pulse tracker
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_r    <= IDLE;
         ts_r       <= {TS_W{1'b0}};
         t0_r       <= {TS_W{1'b0}};
         amp_r      <= {DATA_W{1'b0}};
         wcnt_r     <= {WCNT_W{1'b0}};
         pile_r     <= 1'b0;
         drop_cnt_r <= {DROP_W{1'b0}};
      end else begin
         ts_r <= ts_r + TS_W'(1);
         if (drop_s && (drop_cnt_r != {DROP_W{1'b1}})) begin
            drop_cnt_r <= drop_cnt_r + DROP_W'(1);
         end
         case (state_r)
            IDLE: begin
               if (above_s) begin
                  t0_r    <= ts_r;
                  wcnt_r  <= WCNT_W'(1);
                  pile_r  <= 1'b0;
                  state_r <= RISE;
               end
            end
            RISE: begin
               if (!above_s) begin
                  // Runt: fell back before the flat top was reached.
                  state_r <= IDLE;
               end else begin
                  wcnt_r <= wcnt_inc_s;
                  if (wcnt_r == WCNT_W'(PEAK_DELAY)) begin
                     amp_r   <= filt_data;
                     state_r <= FALL;
                  end
               end
            end
            FALL: begin
               wcnt_r <= wcnt_inc_s;
               if (!above_s) begin
                  pile_r  <= 1'b0;
                  state_r <= IDLE;
               end else begin
                  pile_r <= pile_s;
               end
            end
            default: begin
               state_r <= IDLE;
            end
         endcase
      end
   end

   peak_event_fifo #(
      .DEPTH     (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (push_s),
      .push_data (event_s),
      .full      (fifo_full_s),
      .ready     (ev_ready),
      .valid     (fifo_valid_s),
      .head      (head_s)
   );

   assign ev_valid  = fifo_valid_s;
   assign ev_amp    = head_s.amp;
   assign ev_time   = head_s.tstamp;
   assign ev_pileup = head_s.pileup;
   assign drop_cnt  = drop_cnt_r;

endmodule
